shreg_seq_ctrl: RTL and testbench
=================================

Name: shreg_seq_ctrl

Overview:
- Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its mode select, serial inputs and parallel load data.
- Accepts one command at a time over a valid/ready handshake: load, shift toward LSB, shift toward MSB, or rotate.
- Expands each command into a cycle-accurate train of mode codes, with one register edge per operation, then parks the register in hold.

Parameters:
- CNT_W, 3, width of the shift count; maximum shift count per command is 2**CNT_W-1.
- SD_W, 2**CNT_W, width of the serial-data word supplied with a shift command.

Ports:
- Clck  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 load, 01 shift toward LSB, 10 shift toward MSB, 11 rotate toward LSB.
- cmd_cnt  in  CNT_W  number of shift steps; ignored for load.
- cmd_pdata  in  4  parallel load word.
- cmd_sdata  in  SD_W  serial bits, consumed LSB first.
- q  in  4  current register contents, used only for rotate.
- S  out  2  register mode: 00 load, 01 shift toward LSB (serial in at MSB via Sil), 10 shift toward MSB (serial in at LSB via Sir), 11 hold.
- Sir  out  1  serial input entering at LSB.
- Sil  out  1  serial input entering at MSB.
- Pin  out  4  parallel data to register.
- busy  out  1  a command is executing.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset: while reset=0 the block is in IDLE with S=11, Pin=0, Sir=0, Sil=0, busy=0, done=0. cmd_ready=1 whenever the state is IDLE, including during reset.
- Reset mid-command aborts immediately. The register sees hold from the next edge onward.
- States:
  - IDLE: ready=1.
  - RUN: ready=0, busy=1.
  - DONE: one cycle, done=1, ready=0.
- Transitions: IDLE→RUN when cmd_valid && cmd_ready. RUN→DONE when the remaining count reaches 0. DONE→IDLE unconditionally.
- Accept edge E0: the sequencer latches op, cnt, pdata and sdata. All S/Pin/Sir/Sil outputs are registered.
- Load: during the cycle after E0, S=00 and Pin=cmd_pdata. The register loads at E1. At E1 the state goes to DONE with S=11. done is high for the cycle following E1.
- Shift, cnt=n>0: for cycles E0..E(n-1), S=01 or 10, and the active serial pin carries sdata[k] during step k (k=0..n-1). The inactive serial pin is 0. The register performs n shifts at edges E1..En. DONE follows En.
- cnt=0 for a shift or rotate: no operation. S stays 11, and DONE occupies the cycle after E0.
- Pin=0 for every op except load.
- Remaining count is a down counter, loaded with cnt-1 for n>0. The serial word is a right-shifting copy; bit 0 drives the serial pin.
- Back-to-back commands: a new command is accepted only in IDLE, giving a minimum of 1 idle cycle between commands (after DONE). cmd_valid during RUN/DONE is held off by ready=0.
- cmd_valid deasserting while ready=0 has no effect. Latched values are immune to input changes after E0.

Optional Feature:
- Macro: SHREG_SEQ_ROTATE_EN.
- Defined: op 11 drives S=01 for cnt cycles, with Sil taken combinationally from q[0] each cycle (rotate toward LSB). sdata is ignored.
- Undefined: op 11 is illegal. It is accepted and completes as a cnt=0 no-op (S=11, done one cycle after accept).

Decomposition:
- Shared package shreg_pkg holds:
  - Op-code constants OP_LOAD/OP_SHR/OP_SHL/OP_ROT.
  - Mode constants MODE_LOAD=00, MODE_SHR=01, MODE_SHL=10, MODE_HOLD=11.
  - The state typedef (IDLE, RUN, DONE).
- No sub-module. The counter and serial-word shifter are small enough to stay inline.

Test Plan:
- Reset asserted during RUN of a shift with cnt=5 → next cycle S=11, busy=0, done=0, Sir=Sil=0. After release, cmd_ready=1.
- Load with pdata=4'b1011 → S=00 and Pin=1011 for exactly one cycle, then S=11. done pulses 2 cycles after accept. Register model holds 1011.
- Shift toward LSB, cnt=4, sdata=8'b0000_0110, register preloaded 1111 → Sil sequence 0,1,1,0 over 4 cycles, Sir=0. Register ends 0110. done one cycle later.
- Shift toward MSB with cnt=0 → S never leaves 11, done pulses the cycle after accept, register unchanged.
- Two commands with cmd_valid held high continuously → second accepted only in the IDLE cycle after DONE. cmd_ready stays 0 through RUN and DONE.
- Op 11, cnt=3, q starting 0001: with the macro defined, register sequence 1000, 0100, 0010. With the macro undefined, a no-op and the register stays 0001.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared definitions for the shift-register command sequencer:
// op codes, register mode codes and the sequencer state type.
package shreg_pkg;

    localparam int unsigned REG_W  = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned MODE_W = 2;

    localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
    localparam logic [OP_W-1:0] OP_SHR  = 2'b01;
    localparam logic [OP_W-1:0] OP_SHL  = 2'b10;
    localparam logic [OP_W-1:0] OP_ROT  = 2'b11;

    localparam logic [MODE_W-1:0] MODE_LOAD = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SHR  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SHL  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_HOLD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Register mode used while stepping a shift-type op; rotate moves toward LSB
    function automatic logic [MODE_W-1:0] shift_mode(input logic [OP_W-1:0] op);
        shift_mode = (op == OP_SHL) ? MODE_SHL : MODE_SHR;
    endfunction

endpackage : shreg_pkg

// File: rtl/shreg_seq_ctrl.sv
// Command sequencer driving mode/serial/parallel inputs of a 4-bit universal
// shift register. Rotate (op 11) is only implemented when SHREG_SEQ_ROTATE_EN is defined.
module shreg_seq_ctrl
    import shreg_pkg::*;
#(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned SD_W  = 2**CNT_W
) (
    input  logic              Clck,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic [REG_W-1:0]  cmd_pdata,
    input  logic [SD_W-1:0]   cmd_sdata,
    input  logic [REG_W-1:0]  q,
    output logic [MODE_W-1:0] S,
    output logic              Sir,
    output logic              Sil,
    output logic [REG_W-1:0]  Pin,
    output logic              busy,
    output logic              done
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SD_W-1:0]    r_sd;
    logic [SD_W-1:0]    w_sd_nxt;
    logic               r_rot;
    logic               w_rot_nxt;

    logic [MODE_W-1:0]  r_s;
    logic [MODE_W-1:0]  w_s_nxt;
    logic               r_sir;
    logic               w_sir_nxt;
    logic               r_sil;
    logic               w_sil_nxt;
    logic [REG_W-1:0]   r_pin;
    logic [REG_W-1:0]   w_pin_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic               w_accept;
    logic               w_noop;
    logic               w_last;
    logic               w_unused_q;

    assign w_accept = cmd_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == '0);

    // Commands that never touch the register finish straight from accept
`ifdef SHREG_SEQ_ROTATE_EN
    assign w_noop = (cmd_op != OP_LOAD) && (cmd_cnt == '0);
`else
    assign w_noop = ((cmd_op != OP_LOAD) && (cmd_cnt == '0)) || (cmd_op == OP_ROT);
`endif

    // State register
    always_ff @(posedge Clck or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_noop ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values; everything lands in registers below
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_sd_nxt   = r_sd;
        w_rot_nxt  = 1'b0;
        w_s_nxt    = MODE_HOLD;
        w_sir_nxt  = 1'b0;
        w_sil_nxt  = 1'b0;
        w_pin_nxt  = '0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_noop) begin
                    w_done_nxt = 1'b1;
                end else if (w_accept) begin
                    w_busy_nxt = 1'b1;
                    w_sd_nxt   = cmd_sdata >> 1;
                    if (cmd_op == OP_LOAD) begin
                        w_cnt_nxt = '0;
                        w_s_nxt   = MODE_LOAD;
                        w_pin_nxt = cmd_pdata;
                    end else begin
                        w_cnt_nxt = cmd_cnt - CNT_W'(1);
                        w_s_nxt   = shift_mode(cmd_op);
                        w_rot_nxt = (cmd_op == OP_ROT);
                        w_sir_nxt = (cmd_op == OP_SHL) && cmd_sdata[0];
                        w_sil_nxt = (cmd_op == OP_SHR) && cmd_sdata[0];
                    end
                end
            end
            RUN: begin
                if (w_last) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    w_sd_nxt   = r_sd >> 1;
                    w_s_nxt    = r_s;
                    w_rot_nxt  = r_rot;
                    w_sir_nxt  = (r_s == MODE_SHL) && r_sd[0];
                    w_sil_nxt  = (r_s == MODE_SHR) && !r_rot && r_sd[0];
                end
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered datapath and register-facing outputs
    always_ff @(posedge Clck or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_sd   <= '0;
            r_rot  <= 1'b0;
            r_s    <= MODE_HOLD;
            r_sir  <= 1'b0;
            r_sil  <= 1'b0;
            r_pin  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_sd   <= w_sd_nxt;
            r_rot  <= w_rot_nxt;
            r_s    <= w_s_nxt;
            r_sir  <= w_sir_nxt;
            r_sil  <= w_sil_nxt;
            r_pin  <= w_pin_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign S         = r_s;
    assign Sir       = r_sir;
    assign Pin       = r_pin;
    assign busy      = r_busy;
    assign done      = r_done;

    // Rotate feeds the register's LSB straight back into its MSB input
`ifdef SHREG_SEQ_ROTATE_EN
    assign Sil        = r_sil | (r_rot & q[0]);
    assign w_unused_q = ^q[REG_W-1:1];
`else
    assign Sil        = r_sil;
    assign w_unused_q = ^{q, r_rot};
`endif

endmodule : shreg_seq_ctrl

// File: tb/tb_shreg_seq_ctrl.sv
// Scoreboard bench for shreg_seq_ctrl: a behavioural 4-bit universal shift
// register closes the loop; directed commands push expected traces and completions.
`timescale 1ns/1ps
module tb_shreg_seq_ctrl;
    import shreg_pkg::*;

    localparam int unsigned CNT_W = 3;
    localparam int unsigned SD_W  = 8;

    logic              Clck = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [3:0]        cmd_pdata;
    logic [SD_W-1:0]   cmd_sdata;
    logic [3:0]        q;
    logic [1:0]        S;
    logic              Sir;
    logic              Sil;
    logic [3:0]        Pin;
    logic              busy;
    logic              done;

    logic [3:0]        q_m = 4'b0000;
    int unsigned       cyc = 0;
    int                total = 0;
    int                bad = 0;
    bit                mon_en = 1'b0;
    logic [3:0]        last_q = 4'b0000;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  s;
        logic        sir;
        logic        sil;
        logic [3:0]  pin;
        logic        busy;
    } tr_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  q;
        logic        busy;
        logic        ready;
    } cp_t;

    tr_t tr_q[$];
    cp_t cp_q[$];

    shreg_seq_ctrl #(.CNT_W(CNT_W), .SD_W(SD_W)) dut (
        .Clck      (Clck),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_pdata (cmd_pdata),
        .cmd_sdata (cmd_sdata),
        .q         (q),
        .S         (S),
        .Sir       (Sir),
        .Sil       (Sil),
        .Pin       (Pin),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clck = ~Clck;

    always @(posedge Clck) cyc <= cyc + 1;

    // Behavioural universal shift register driven by the sequencer
    always @(posedge Clck) begin
        case (S)
            MODE_LOAD: q_m <= Pin;
            MODE_SHR:  q_m <= {Sil, q_m[3:1]};
            MODE_SHL:  q_m <= {q_m[2:0], Sir};
            default:   q_m <= q_m;
        endcase
    end
    assign q = q_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any non-idle register drive or done pulse is checked against the queues
    always @(negedge Clck) begin : mon
        tr_t act_t;
        tr_t exp_t;
        cp_t act_c;
        cp_t exp_c;
        if (mon_en && reset) begin
            if (S != MODE_HOLD || Sir || Sil || Pin != 4'd0) begin
                act_t = '{cyc, S, Sir, Sil, Pin, busy};
                if (tr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL trace_unexpected: got %h expected none", act_t);
                end else begin
                    exp_t = tr_q.pop_front();
                    chk("trace", 64'(act_t), 64'(exp_t));
                end
            end
            if (done) begin
                act_c = '{cyc, q_m, busy, cmd_ready};
                if (cp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got %h expected none", act_c);
                end else begin
                    exp_c = cp_q.pop_front();
                    chk("completion", 64'(act_c), 64'(exp_c));
                end
            end
        end
    end

    // Drive one command, push its expected register-drive trace and completion
    task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] pd,
                         input logic [7:0] sd, input logic [3:0] exp_q, input bit keep,
                         output int unsigned acc);
        int unsigned lat;
        int          guard;
        logic [3:0]  qq;
        @(negedge Clck);
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_pdata = pd;
        cmd_sdata = sd;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge Clck);
            guard++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
            cmd_valid = 1'b0;
            acc = 0;
            return;
        end
        acc = cyc + 1;
        lat = 0;
        case (op)
            OP_LOAD: begin
                tr_q.push_back('{acc, MODE_LOAD, 1'b0, 1'b0, pd, 1'b1});
                lat = 1;
            end
            OP_SHR, OP_SHL: begin
                for (int k = 0; k < int'(cnt); k++) begin
                    tr_q.push_back('{acc + 32'(k), (op == OP_SHR) ? MODE_SHR : MODE_SHL,
                                     (op == OP_SHL) ? sd[k] : 1'b0,
                                     (op == OP_SHR) ? sd[k] : 1'b0, 4'd0, 1'b1});
                end
                lat = 32'(cnt);
            end
            default: begin
`ifdef SHREG_SEQ_ROTATE_EN
                qq = last_q;
                for (int k = 0; k < int'(cnt); k++) begin
                    tr_q.push_back('{acc + 32'(k), MODE_SHR, 1'b0, qq[0], 4'd0, 1'b1});
                    qq = {qq[0], qq[3:1]};
                end
                lat = 32'(cnt);
`else
                qq = last_q;
                lat = 0;
`endif
            end
        endcase
        cp_q.push_back('{acc + lat, exp_q, 1'b0, 1'b0});
        last_q = exp_q;
        @(posedge Clck);
        #1;
        if (!keep) begin
            cmd_valid = 1'b0;
            cmd_op    = ~op;
            cmd_cnt   = ~cnt;
            cmd_pdata = ~pd;
            cmd_sdata = ~sd;
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while ((tr_q.size() != 0 || cp_q.size() != 0) && g < 40) begin
            @(negedge Clck);
            g++;
        end
        if (tr_q.size() != 0 || cp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d/%0d pending expected 0/0", tr_q.size(), cp_q.size());
            tr_q.delete();
            cp_q.delete();
        end
        @(negedge Clck);
    endtask

    initial begin
        int unsigned a1;
        int unsigned a2;
        logic [3:0]  rot_exp;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_pdata = '0;
        cmd_sdata = '0;

        repeat (2) @(negedge Clck);
        chk("reset_state", 64'({S, Sir, Sil, Pin, busy, done, cmd_ready}),
            64'({2'b11, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}));
        reset = 1'b1;

        // Abort a cnt=5 shift part way through with an async reset
        @(negedge Clck);
        cmd_op = OP_SHR; cmd_cnt = 3'd5; cmd_sdata = 8'hFF; cmd_valid = 1'b1;
        @(posedge Clck);
        #1 cmd_valid = 1'b0;
        repeat (2) @(negedge Clck);
        chk("run_before_abort", 64'({S, busy, Sil, cmd_ready}), 64'({MODE_SHR, 1'b1, 1'b1, 1'b0}));
        #2 reset = 1'b0;
        #1 chk("abort_immediate", 64'({S, busy, done, Sir, Sil, Pin, cmd_ready}),
               64'({2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1}));
        @(negedge Clck);
        chk("abort_next_cycle", 64'({S, busy, done, Sir, Sil}), 64'({2'b11, 1'b0, 1'b0, 1'b0, 1'b0}));
        reset = 1'b1;
        @(negedge Clck);
        chk("ready_after_release", 64'({cmd_ready, S, busy}), 64'({1'b1, 2'b11, 1'b0}));
        mon_en = 1'b1;

        issue(OP_LOAD, 3'd0, 4'b1011, 8'h00, 4'b1011, 1'b0, a1);  wait_done();
        issue(OP_LOAD, 3'd0, 4'b1111, 8'h00, 4'b1111, 1'b0, a1);  wait_done();
        issue(OP_SHR,  3'd4, 4'b0000, 8'b0000_0110, 4'b0110, 1'b0, a1);  wait_done();
        issue(OP_SHL,  3'd3, 4'b0000, 8'b0000_0101, 4'b0101, 1'b0, a1);  wait_done();
        issue(OP_SHL,  3'd0, 4'b0000, 8'hFF, 4'b0101, 1'b0, a1);  wait_done();
        issue(OP_SHR,  3'd7, 4'b0000, 8'b1010_0101, 4'b0100, 1'b0, a1);  wait_done();

        // cmd_valid held high across two commands
        issue(OP_LOAD, 3'd0, 4'b1100, 8'h00, 4'b1100, 1'b1, a1);
        issue(OP_SHL,  3'd2, 4'b0000, 8'h03, 4'b0011, 1'b0, a2);
        chk("b2b_accept_cycle", 64'(a2), 64'(a1 + 3));
        wait_done();

`ifdef SHREG_SEQ_ROTATE_EN
        rot_exp = 4'b0010;
`else
        rot_exp = 4'b0001;
`endif
        issue(OP_LOAD, 3'd0, 4'b0001, 8'h00, 4'b0001, 1'b0, a1);  wait_done();
        issue(OP_ROT,  3'd3, 4'b0000, 8'hFF, rot_exp, 1'b0, a1);  wait_done();

        repeat (3) @(negedge Clck);
        chk("final_reg", 64'(q_m), 64'(rot_exp));
        chk("queues_drained", 64'({tr_q.size(), cp_q.size()}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule : tb_shreg_seq_ctrl
